pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program sequencer for the 8-bit, 9-bit-instruction core. It owns the program counter and the run/halt state machine, and drives the fetch address into instruction memory. It consumes the decoder's Branch flag, a resolved branch target, a halt decode and an ALU stall, and returns a done flag plus a retired-instruction count to the top level and testbench.

## Interface

Parameters:
- PC_W, default 10: program counter width; instruction memory depth is 2^PC_W.
- CNT_W, default 16: retired-instruction counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  level request to run; sampled only in IDLE and HALT
- start_addr  in  PC_W  PC loaded on IDLE->RUN
- Branch  in  1  taken-branch flag from the control decoder, already condition-resolved
- br_target  in  PC_W  absolute target used when Branch=1
- halt  in  1  current instruction is the halt encoding
- stall  in  1  datapath not ready (multi-cycle mul); hold the current instruction
- pc  out  PC_W  fetch address of the instruction being executed
- exec_valid  out  1  current instruction completes this cycle (register/memory writes enabled)
- done  out  1  program finished
- instr_cnt  out  CNT_W  retired instructions since the last IDLE->RUN
- state  out  2  IDLE=0, RUN=1, HALT=2 (debug)

## Operation

- States: IDLE, RUN, HALT. Encoding 3 is illegal and returns to IDLE on the next edge.
- IDLE:
  - pc holds its value; exec_valid=0, done=0.
  - start=1 -> RUN next cycle; pc<=start_addr, instr_cnt<=0.
- RUN, one instruction per cycle at pc, with this priority:
  - stall=1: exec_valid=0; pc, instr_cnt and state hold. Branch and halt are ignored.
  - halt=1: exec_valid=1; instr_cnt increments; pc holds; next state HALT. Halt counts as retired.
  - Branch=1: exec_valid=1; pc<=br_target; instr_cnt increments.
  - otherwise: exec_valid=1; pc<=pc+1, modulo 2^PC_W. Wrap from all-ones to 0 is silent.
- HALT:
  - done=1; exec_valid=0; pc and instr_cnt frozen.
  - start=0 -> IDLE next cycle (done drops).
  - start held high stays in HALT, so one start level gives exactly one run.
- instr_cnt saturates at 2^CNT_W-1; it never wraps.
- exec_valid is combinational from state and stall: (state==RUN)&&!stall. Everything else is registered.
- Branch, halt and stall are treated as don't-care outside RUN.

## Timing

- Reset (sync, active-high): state=IDLE, pc=0, instr_cnt=0, done=0, exec_valid=0. Reset has priority over every other input, including mid-RUN and during stall.
- Start to first execute: start=1 at edge N (in IDLE) -> state=RUN and pc=start_addr after edge N. The first exec_valid=1 is in cycle N+1.
- Per-instruction latency: 1 cycle when stall=0. Each stall cycle adds 1 cycle; the instruction is re-presented at the same pc.
- Branch to next fetch: Branch=1 in cycle k -> pc=br_target in cycle k+1. There is no delay slot and no bubble.
- Halt to done: halt=1 in cycle k -> done=1 from cycle k+1. Final instr_cnt is visible in cycle k+1.
- done to IDLE: 1 cycle after start is sampled low in HALT.
- Simultaneous Branch and halt: halt wins and pc holds.
- Simultaneous stall with anything: stall wins.

## Test plan

- Reset/launch: hold reset 2 cycles with start=1. Then expect pc=0, done=0, state=IDLE. Release reset with start_addr=0x010: pc=0x010 in the next cycle and exec_valid=1.
- Sequential run to halt: run from 0x000 with 5 non-branch cycles, then halt. Expect pc to step 0..5, done=1 at cycle 7, instr_cnt=6, pc frozen at 5.
- Branch and stall: at pc=3, Branch=1 with br_target=0x200 -> pc=0x200 in the next cycle. At 0x200, stall for 3 cycles -> pc stays 0x200, exec_valid=0, and instr_cnt does not change for those 3 cycles.
- Wrap and priority:
  - start_addr=0x3FF, no branch -> pc=0x000 in the next cycle.
  - Branch=1 with halt=1 -> state HALT, pc unchanged.
  - stall=1 with halt=1 -> stays in RUN.
- Rerun handshake: in HALT, hold start=1 for 10 cycles -> done stays 1 and there is no rerun. Drop start -> IDLE. Raise start -> instr_cnt=0 and pc=start_addr.
- Saturation and mid-run reset: with CNT_W=4, run 20 instructions -> instr_cnt=15. Assert reset mid-RUN -> all outputs return to reset values in the next cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Bus between the core control path and the program sequencer: run request,
// branch/halt/stall inputs from the decoder and datapath, and the PC, retire
// and status outputs returned by the sequencer.
interface pc_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             Branch;
    logic [PC_W-1:0]  br_target;
    logic             halt;
    logic             stall;
    logic [PC_W-1:0]  pc;
    logic             exec_valid;
    logic             done;
    logic [CNT_W-1:0] instr_cnt;
    logic [1:0]       state;

    // Core/top-level side: issues requests and decode results.
    modport master (
        output start, start_addr, Branch, br_target, halt, stall,
        input  pc, exec_valid, done, instr_cnt, state
    );

    // Sequencer side: owns the PC and the run/halt state.
    modport slave (
        input  start, start_addr, Branch, br_target, halt, stall,
        output pc, exec_valid, done, instr_cnt, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the program counter, the IDLE/RUN/HALT state
// machine and a saturating retired-instruction counter. One instruction is
// executed per RUN cycle unless the datapath stalls.
module pc_sequencer #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q;

    // Retire count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state, next-PC and retire-count decision; stall beats halt beats Branch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (!bus.stall) begin
                    cnt_d = sat_inc(cnt_q);
                    if (bus.halt) begin
                        state_d = HALT;
                    end else if (bus.Branch) begin
                        pc_d = bus.br_target;
                    end else begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            HALT: begin
                // A held start level keeps us here so one request gives one run.
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, PC, counter and done registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_d == HALT);
        end
    end

    assign bus.pc         = pc_q;
    assign bus.exec_valid = (state_q == RUN) && !bus.stall;
    assign bus.done       = done_q;
    assign bus.instr_cnt  = cnt_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (16-bit and 4-bit retire counters)
// share directed stimulus; a behavioural model is compared every cycle and
// literal expectations pin key points of the scenario.
module tb_pc_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [9:0] start_addr;
    logic       Branch;
    logic [9:0] br_target;
    logic       halt;
    logic       stall;

    int n_vec = 0;
    int n_bad = 0;

    pc_sequencer_if #(.PC_W(10), .CNT_W(16)) if16 ();
    pc_sequencer_if #(.PC_W(10), .CNT_W(4))  if4 ();

    assign if16.start      = start;
    assign if16.start_addr = start_addr;
    assign if16.Branch     = Branch;
    assign if16.br_target  = br_target;
    assign if16.halt       = halt;
    assign if16.stall      = stall;
    assign if4.start       = start;
    assign if4.start_addr  = start_addr;
    assign if4.Branch      = Branch;
    assign if4.br_target   = br_target;
    assign if4.halt        = halt;
    assign if4.stall       = stall;

    pc_sequencer #(.PC_W(10), .CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
    pc_sequencer #(.PC_W(10), .CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(if4.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Behavioural model: mode 0=idle, 1=running, 2=halted; retired is an
    // unbounded count that is clamped per counter width when compared.
    int m_mode;
    int m_pc;
    int m_retired;
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_mode    <= 0;
            m_pc      <= 0;
            m_retired <= 0;
            m_ok      <= 1'b1;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode    <= 1;
                m_pc      <= int'(start_addr);
                m_retired <= 0;
            end
        end else if (m_mode == 1) begin
            if (!stall) begin
                m_retired <= m_retired + 1;
                if (halt)        m_mode <= 2;
                else if (Branch) m_pc   <= int'(br_target);
                else             m_pc   <= (m_pc + 1) % 1024;
            end
        end else begin
            if (!start) m_mode <= 0;
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            check("pc16",    int'(if16.pc),         m_pc);
            check("ev16",    int'(if16.exec_valid), int'(m_mode == 1 && !stall));
            check("done16",  int'(if16.done),       int'(m_mode == 2));
            check("state16", int'(if16.state),      m_mode);
            check("cnt16",   int'(if16.instr_cnt),  (m_retired > 65535) ? 65535 : m_retired);
            check("pc4",     int'(if4.pc),          m_pc);
            check("ev4",     int'(if4.exec_valid),  int'(m_mode == 1 && !stall));
            check("done4",   int'(if4.done),        int'(m_mode == 2));
            check("state4",  int'(if4.state),       m_mode);
            check("cnt4",    int'(if4.instr_cnt),   (m_retired > 15) ? 15 : m_retired);
        end
    end

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait to the sampling point of the current cycle.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; start_addr = 10'h000;
        Branch = 1'b0; br_target = 10'h000; halt = 1'b0; stall = 1'b0;

        // Reset held two cycles with start high.
        step(2);
        mid();
        check("lit_rst_pc",    int'(if16.pc), 0);
        check("lit_rst_done",  int'(if16.done), 0);
        check("lit_rst_state", int'(if16.state), 0);
        check("lit_rst_ev",    int'(if16.exec_valid), 0);

        // Launch at 0x010.
        reset = 1'b0; start_addr = 10'h010;
        step(1);
        mid();
        check("lit_launch_pc", int'(if16.pc), 16);
        check("lit_launch_ev", int'(if16.exec_valid), 1);
        #1 halt = 1'b1;
        step(1);
        halt = 1'b0; start = 1'b0;
        step(1);

        // Sequential run from 0 to halt.
        start = 1'b1; start_addr = 10'h000;
        step(1);
        step(5);
        mid();
        check("lit_seq_pc",  int'(if16.pc), 5);
        check("lit_seq_cnt", int'(if16.instr_cnt), 5);
        #1 halt = 1'b1;
        step(1);
        halt = 1'b0;
        mid();
        check("lit_halt_done", int'(if16.done), 1);
        check("lit_halt_cnt",  int'(if16.instr_cnt), 6);
        check("lit_halt_pc",   int'(if16.pc), 5);

        // Start held high in HALT: no rerun.
        #1 step(10);
        mid();
        check("lit_hold_done",  int'(if16.done), 1);
        check("lit_hold_state", int'(if16.state), 2);
        check("lit_hold_cnt",   int'(if16.instr_cnt), 6);
        #1 start = 1'b0;
        step(1);
        mid();
        check("lit_idle_state", int'(if16.state), 0);
        check("lit_idle_done",  int'(if16.done), 0);

        // Relaunch, branch at pc=3, then stall three cycles.
        #1 start = 1'b1; start_addr = 10'h000;
        step(1);
        mid();
        check("lit_rerun_cnt", int'(if16.instr_cnt), 0);
        check("lit_rerun_pc",  int'(if16.pc), 0);
        #1 step(3);
        Branch = 1'b1; br_target = 10'h200;
        step(1);
        Branch = 1'b0; stall = 1'b1;
        mid();
        check("lit_br_pc", int'(if16.pc), 10'h200);
        #1 step(3);
        mid();
        check("lit_stall_pc",  int'(if16.pc), 10'h200);
        check("lit_stall_ev",  int'(if16.exec_valid), 0);
        check("lit_stall_cnt", int'(if16.instr_cnt), 4);
        #1 stall = 1'b0; halt = 1'b1;
        step(1);
        halt = 1'b0; start = 1'b0;
        step(1);

        // Wrap from 0x3FF, then simultaneous Branch and halt.
        start = 1'b1; start_addr = 10'h3FF;
        step(1);
        step(1);
        mid();
        check("lit_wrap_pc", int'(if16.pc), 0);
        #1 Branch = 1'b1; halt = 1'b1; br_target = 10'h123;
        step(1);
        Branch = 1'b0; halt = 1'b0;
        mid();
        check("lit_brhalt_state", int'(if16.state), 2);
        check("lit_brhalt_pc",    int'(if16.pc), 0);
        #1 start = 1'b0;
        step(1);

        // Stall together with halt stays in RUN.
        start = 1'b1; start_addr = 10'h050;
        step(1);
        stall = 1'b1; halt = 1'b1;
        step(2);
        mid();
        check("lit_stallhalt_state", int'(if16.state), 1);
        check("lit_stallhalt_pc",    int'(if16.pc), 10'h050);
        #1 stall = 1'b0;
        step(1);
        halt = 1'b0; start = 1'b0;
        step(1);

        // Twenty instructions: the 4-bit counter saturates.
        start = 1'b1; start_addr = 10'h100;
        step(1);
        step(20);
        mid();
        check("lit_sat_cnt4",  int'(if4.instr_cnt), 15);
        check("lit_sat_cnt16", int'(if16.instr_cnt), 20);
        check("lit_sat_pc",    int'(if16.pc), 10'h114);

        // Reset mid-RUN while stalled.
        #1 stall = 1'b1; reset = 1'b1;
        step(1);
        mid();
        check("lit_mreset_pc",    int'(if16.pc), 0);
        check("lit_mreset_state", int'(if16.state), 0);
        check("lit_mreset_cnt",   int'(if4.instr_cnt), 0);
        check("lit_mreset_done",  int'(if16.done), 0);
        check("lit_mreset_ev",    int'(if16.exec_valid), 0);
        #1 reset = 1'b0; stall = 1'b0; start = 1'b0;
        step(2);
        mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
